injetor_stream: RTL
===================

// Module: injetor_stream
// PURPOSE
//  Clocked, parametrised error injector for parity-protected words on a valid/ready stream.
//  Sits between the parity generator and the parity checker.
//  Flips chosen bits of passing words in one of three modes: single-shot, periodic or walking-bit.
//  Counts injections, so the checker's detection rate can be compared against ground truth.
// PARAMETERS
//  W      9   word width, data plus parity bit (W >= 2)
//  IW     4   bit-index width; must satisfy 2**IW >= W
//  PER_W  16  width of the period counter and of the period config
//  CNT_W  16  width of the injection counter
// PORTS
//  clk          in   1      clock; all logic is rising-edge
//  rst          in   1      asynchronous reset, active-high
//  in_valid     in   1      upstream word valid
//  in_ready     out  1      block can accept a word
//  entrada      in   W      upstream word
//  out_valid    out  1      output word valid
//  out_ready    in   1      downstream accepts the word
//  saida        out  W      output word, possibly corrupted
//  injetado     out  1      qualifies saida: 1 = this word was corrupted
//  cfg_arm      in   1      one-cycle pulse; latches the cfg_* inputs and starts the mode
//  cfg_modo     in   2      00 off, 01 single-shot, 10 periodic, 11 walking
//  cfg_bit      in   IW     bit index to flip; start index in walking mode
//  cfg_periodo  in   PER_W  periodic mode: corrupt every cfg_periodo-th word
//  ativo        out  1      1 while state != IDLE
//  cont_inj     out  CNT_W  saturating count of corrupted words delivered
// BEHAVIOUR
//  Reset values: state=IDLE; out_valid=0; saida=0; injetado=0; cont_inj=0.
//   Latched bit, latched period and word counter reset to 0.
//  Datapath: one output register, latency 1 cycle.
//   in_ready = !out_valid || out_ready.
//   Accept occurs when in_valid && in_ready. On accept: saida <= entrada ^ mask, injetado <= (mask != 0).
//   Output holds saida and injetado stable while out_valid && !out_ready.
//  Mask: (1 << bit_lat) when the current word is selected, else 0.
//   If bit_lat >= W, mask = 0: no flip, injetado = 0, no count.
//  FSM states: IDLE, UNICO, CONTINUO.
//   cfg_arm with modo 00 -> IDLE.
//   cfg_arm with modo 01 -> UNICO.
//   cfg_arm with modo 10 or 11 -> CONTINUO.
//   Every cfg_arm, from any state, re-latches bit and period and clears the word counter.
//  UNICO: the first accepted word is selected; then go to IDLE on the same edge.
//  CONTINUO, periodic mode: the word counter increments on each accept.
//   When counter+1 >= per_lat, the word is selected and the counter returns to 0.
//   per_lat of 0 or 1 selects every word.
//  CONTINUO, walking mode: every accepted word is selected.
//   After each selected word, bit_lat <= (bit_lat == W-1) ? 0 : bit_lat + 1.
//   Out-of-range bit_lat still advances and wraps at 2**IW - 1.
//  cfg_arm in the same cycle as an accept: the word uses the pre-arm state and config.
//   The new config applies from the next word. The arm also wins over UNICO's return to IDLE.
//  cont_inj increments when the output handshake completes (out_valid && out_ready && injetado).
//   It saturates at all-ones.
//  With no accept, state, counters and bit_lat hold. Back-pressure never drops or duplicates a word.
//  rst mid-operation: the pending output word is discarded (out_valid=0), the FSM goes to IDLE, config and counters clear.
// CONFIGURATION
//  INJETOR_DUPLO_ERRO_EN defined:
//   Selected words get mask = (1<<b) | (1<<((b == W-1) ? 0 : b+1)), where b = bit_lat.
//   This is a double flip, which parity cannot detect. Out-of-range b still gives mask 0.
//  Not defined: single-bit mask only, as above. Ports are identical in both builds.
// TESTING
//  1. modo 00; stream 0x0AA,0x155,0x1FF with out_ready=1 -> saida equals entrada one cycle later.
//     injetado=0, cont_inj=0.
//  2. arm modo 01, bit 8; send 0x0F0,0x0F0 -> outputs 0x1F0 (injetado=1) then 0x0F0.
//     ativo returns to 0; cont_inj=1.
//  3. arm modo 10, periodo 3; send 6 words of 0x000, bit 0 -> words 3 and 6 read 0x001, others 0x000.
//     cont_inj=2.
//  4. arm modo 11, bit 7; send 4 words of 0x000 -> outputs 0x080, 0x100, 0x001, 0x002 (wrap at W-1).
//  5. modo 10, periodo 1; hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and saida stable.
//     No word is lost or duplicated after release. Assert rst mid-stream -> out_valid=0, ativo=0, cont_inj=0.
//  6. INJETOR_DUPLO_ERRO_EN, arm modo 01, bit 8, word 0x000 -> saida 0x101, injetado=1.
//     Also: bit 12 -> no flip, injetado=0.

Source files
------------

// File: rtl/injetor_stream_if.sv
// Stream bundle for the error injector: upstream word in, downstream word out.
//   in_valid/in_ready/entrada         upstream valid/ready handshake and word
//   out_valid/out_ready/saida         downstream valid/ready handshake and word
//   injetado                          qualifies saida: 1 = word was corrupted
// Modports: slave = injector side, master = environment (producer + consumer).
interface injetor_stream_if #(
    parameter int W = 9
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] entrada;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] saida;
    logic         injetado;

    modport slave (
        input  in_valid, entrada, out_ready,
        output in_ready, out_valid, saida, injetado
    );

    modport master (
        output in_valid, entrada, out_ready,
        input  in_ready, out_valid, saida, injetado
    );
endinterface

// File: rtl/injetor_stream.sv
// Error injector for parity-protected words on a valid/ready stream. Sits
// between parity generator and checker and flips chosen bits in single-shot,
// periodic or walking-bit mode, counting delivered corrupted words.
// Ports:
//   clk, rst      clock (rising edge) and async active-high reset
//   s             stream bundle (injetor_stream_if.slave), 1-cycle latency
//   cfg_arm       one-cycle pulse: latch cfg_* and start the selected mode
//   cfg_modo      00 off, 01 single-shot, 10 periodic, 11 walking
//   cfg_bit       bit index to flip (start index when walking)
//   cfg_periodo   periodic mode: corrupt every cfg_periodo-th word
//   ativo         1 while the FSM is not IDLE
//   cont_inj      saturating count of corrupted words delivered
// Build option: INJETOR_DUPLO_ERRO_EN flips bit b and its wrap-around
// neighbour, a double error that parity cannot detect.
//
// state    | meaning
// IDLE     | no injection, words pass unmodified
// UNICO    | corrupt the next accepted word, then return to IDLE
// CONTINUO | periodic or walking injection until re-armed
module injetor_stream #(
    parameter int W     = 9,
    parameter int IW    = 4,
    parameter int PER_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    injetor_stream_if.slave  s,
    input  logic             cfg_arm,
    input  logic [1:0]       cfg_modo,
    input  logic [IW-1:0]    cfg_bit,
    input  logic [PER_W-1:0] cfg_periodo,
    output logic             ativo,
    output logic [CNT_W-1:0] cont_inj
);
    typedef enum logic [1:0] {IDLE, UNICO, CONTINUO} state_t;

    localparam logic [IW-1:0] ULT = IW'(W - 1);

    state_t           state;
    logic [IW-1:0]    bit_lat;
    logic [PER_W-1:0] per_lat;
    logic [PER_W-1:0] cnt;
    logic             walk_lat;

    logic             accept;
    logic             sel;
    logic             in_range;
    logic [IW-1:0]    b_next;
    logic [PER_W:0]   cnt_inc;
    logic [W-1:0]     mask;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;
    assign ativo      = (state != IDLE);

    always_comb begin
        // Extra top bit keeps cnt+1 from wrapping before the compare.
        cnt_inc  = {1'b0, cnt} + 1'b1;
        b_next   = (bit_lat == ULT) ? '0 : bit_lat + IW'(1);
        in_range = (bit_lat <= ULT);
        sel      = 1'b0;
        case (state)
            UNICO:    sel = 1'b1;
            CONTINUO: sel = walk_lat || (cnt_inc >= {1'b0, per_lat});
            default:  sel = 1'b0;
        endcase
        mask = '0;
        if (sel && in_range) begin
            mask = W'(1) << bit_lat;
`ifdef INJETOR_DUPLO_ERRO_EN
            mask = mask | (W'(1) << b_next);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_lat    <= '0;
            per_lat    <= '0;
            cnt        <= '0;
            walk_lat   <= 1'b0;
            s.out_valid <= 1'b0;
            s.saida    <= '0;
            s.injetado <= 1'b0;
            cont_inj   <= '0;
        end else begin
            if (accept) begin
                s.out_valid <= 1'b1;
                s.saida     <= s.entrada ^ mask;
                s.injetado  <= (mask != '0);
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end

            if (s.out_valid && s.out_ready && s.injetado && !(&cont_inj))
                cont_inj <= cont_inj + 1'b1;

            // An arm overrides whatever the accepted word would have done to
            // the FSM; the word itself was already masked with the old config.
            if (cfg_arm) begin
                bit_lat  <= cfg_bit;
                per_lat  <= cfg_periodo;
                cnt      <= '0;
                walk_lat <= cfg_modo[0];
                case (cfg_modo)
                    2'b00:   state <= IDLE;
                    2'b01:   state <= UNICO;
                    default: state <= CONTINUO;
                endcase
            end else if (accept) begin
                case (state)
                    UNICO: state <= IDLE;
                    CONTINUO: begin
                        if (walk_lat)
                            bit_lat <= b_next;
                        else
                            cnt <= sel ? '0 : cnt_inc[PER_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
